philv_fetch_unit: RTL and testbench

Instruction fetch stage for the Philosophy-V core: owns the program counter, issues word reads to the instruction port of the dual-port memory, and delivers instructions with their PC to decode through a valid/ready handshake. Sits directly upstream of the instruction register / ALU decoder path and replaces the externally driven fetch address. Accepts branch/jump redirects from execute and flags misaligned redirect targets.

---
 rtl/philv_fetch_unit_pkg.sv | 20 ++
 rtl/philv_fetch_queue.sv | 84 ++++++++
 rtl/philv_fetch_unit.sv | 127 ++++++++++++
 tb/tb_philv_fetch_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/philv_fetch_unit_pkg.sv
// Shared fetch-stage definitions for the Philosophy-V core: widths, reset PC,
// PC increment and the fetch FSM state encoding.
package philv_fetch_unit_pkg;

    localparam int          INSTR_WIDTH      = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          PC_INC           = 4;
    localparam int          QUEUE_DEPTH      = 2;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/philv_fetch_queue.sv
// Two-entry instruction FIFO of {pc, instr}. The head entry is presented
// directly from storage, so all outputs are registered.
module philv_fetch_queue
    import philv_fetch_unit_pkg::*;
#(
    parameter int W = INSTR_WIDTH
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         push,
    input  logic [W-1:0] push_pc,
    input  logic [W-1:0] push_instr,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output logic         head_valid,
    output logic [W-1:0] head_pc,
    output logic [W-1:0] head_instr
);

    logic [W-1:0] pc_q    [QUEUE_DEPTH];
    logic [W-1:0] pc_d    [QUEUE_DEPTH];
    logic [W-1:0] instr_q [QUEUE_DEPTH];
    logic [W-1:0] instr_d [QUEUE_DEPTH];
    // Depth is two, so a single toggling bit addresses each slot.
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         pop_ok;
    logic         push_ok;

    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pop_ok   = pop && (count_q != 2'd0);
        push_ok  = push && ((count_q != 2'(QUEUE_DEPTH)) || pop_ok);

        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_ok) begin
                pc_d[wr_ptr_q]    = push_pc;
                instr_d[wr_ptr_q] = push_instr;
                wr_ptr_d          = ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    // NOTE: storage is reset too, because the head slot is visible as instr/instr_pc and must read 0 out of reset.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != 2'd0);
    assign head_pc    = pc_q[rd_ptr_q];
    assign head_instr = instr_q[rd_ptr_q];

endmodule

// File: rtl/philv_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to the instruction
// port and hands {instr, pc} to decode through a valid/ready handshake.
module philv_fetch_unit
    import philv_fetch_unit_pkg::*;
#(
    parameter int                   BUS_WIDTH = INSTR_WIDTH,
    parameter logic [BUS_WIDTH-1:0] RESET_PC  = BUS_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 rstb,
    output logic                 mem_req,
    output logic [BUS_WIDTH-1:0] mem_addr,
    input  logic [BUS_WIDTH-1:0] mem_rdata,
    input  logic                 redirect_valid,
    input  logic [BUS_WIDTH-1:0] redirect_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [BUS_WIDTH-1:0] instr,
    output logic [BUS_WIDTH-1:0] instr_pc,
    output logic                 fetch_fault
);

    localparam logic [BUS_WIDTH-1:0] PC_STEP = BUS_WIDTH'(PC_INC);

    fetch_state_e         state_q, state_d;
    logic [BUS_WIDTH-1:0] pc_q, pc_d;
    logic                 inflight_q, inflight_d;
    logic [BUS_WIDTH-1:0] req_pc_q, req_pc_d;

    logic                 redirect_ok;
    logic                 redirect_bad;
    logic                 flush;
    logic                 pop;
    logic                 push;
    logic                 room;
    logic [1:0]           q_count;
    logic [2:0]           occupancy;

    assign redirect_ok  = redirect_valid && is_word_aligned(redirect_pc[1:0]);
    assign redirect_bad = redirect_valid && !is_word_aligned(redirect_pc[1:0]);
    assign pop          = instr_valid && instr_ready;

    // Queued entries plus the response landing this cycle; a same-cycle pop frees one slot.
    assign occupancy = {1'b0, q_count} + {2'b00, inflight_q};
    assign room      = occupancy < (3'd2 + {2'b00, pop});

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        mem_req    = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (redirect_bad) begin
                        state_d = ST_FAULT;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else begin
                    push    = inflight_q;
                    mem_req = room;
                    if (room) begin
                        pc_d     = pc_q + PC_STEP;
                        req_pc_d = pc_q;
                    end
                end
            end
            ST_FAULT: begin
                // Only an aligned redirect leaves FAULT; anything else keeps fetch parked.
                if (redirect_valid) begin
                    flush = 1'b1;
                end
                if (redirect_ok) begin
                    state_d = ST_RUN;
                    pc_d    = redirect_pc;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        inflight_d = mem_req;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            req_pc_q   <= req_pc_d;
        end
    end

    philv_fetch_queue #(
        .W (BUS_WIDTH)
    ) u_queue (
        .clk        (clk),
        .rstb       (rstb),
        .push       (push),
        .push_pc    (req_pc_q),
        .push_instr (mem_rdata),
        .pop        (pop),
        .flush      (flush),
        .count      (q_count),
        .head_valid (instr_valid),
        .head_pc    (instr_pc),
        .head_instr (instr)
    );

    assign mem_addr    = pc_q;
    assign fetch_fault = (state_q == ST_FAULT);

endmodule

// File: tb/tb_philv_fetch_unit.sv
// Self-checking bench for philv_fetch_unit: a request/delivery model plus a
// per-cycle trace used for hand-computed timing expectations.
module tb_philv_fetch_unit;

    localparam logic [31:0] KEY      = 32'hA5A5_0000;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] NO_DATA  = 32'hDEAD_BEEF;
    localparam int          TRACE_N  = 1024;

    logic        clk = 1'b0;
    logic        rstb;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = NO_DATA;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    philv_fetch_unit #(
        .BUS_WIDTH (32),
        .RESET_PC  (RST_PC)
    ) dut (
        .clk            (clk),
        .rstb           (rstb),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    // Instruction memory: data for a request appears the following cycle.
    always @(posedge clk) begin
        mem_rdata <= mem_req ? (mem_addr ^ KEY) : NO_DATA;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle trace, indexed by a free-running cycle number.
    int          gcyc = 0;
    logic        tr_req   [TRACE_N];
    logic [31:0] tr_addr  [TRACE_N];
    logic        tr_valid [TRACE_N];
    logic [31:0] tr_pc    [TRACE_N];
    logic        tr_fault [TRACE_N];

    // Model: every request is an item that becomes deliverable two cycles later,
    // delivered in request order, and discarded by a flush.
    typedef struct {
        int          c;
        logic [31:0] pc;
    } item_t;

    item_t       mq[$];
    int          cyc = 0;
    bit          faulted = 1'b0;
    logic [31:0] exp_req_pc = RST_PC;
    bit          hold_v = 1'b0;
    logic [31:0] hold_i, hold_p;

    always @(negedge clk) begin
        bit pop;
        bit exp_valid;
        bit exp_req;
        if (gcyc < TRACE_N) begin
            tr_req[gcyc]   = mem_req;
            tr_addr[gcyc]  = mem_addr;
            tr_valid[gcyc] = instr_valid;
            tr_pc[gcyc]    = instr_pc;
            tr_fault[gcyc] = fetch_fault;
        end
        if (!rstb) begin
            check("rst_mem_req", {31'd0, mem_req}, 32'd0);
            check("rst_mem_addr", mem_addr, RST_PC);
            check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
            check("rst_instr", instr, 32'd0);
            check("rst_instr_pc", instr_pc, 32'd0);
            check("rst_fetch_fault", {31'd0, fetch_fault}, 32'd0);
            mq.delete();
            faulted    = 1'b0;
            exp_req_pc = RST_PC;
            hold_v     = 1'b0;
            cyc        = 0;
        end else begin
            pop       = instr_valid && instr_ready;
            exp_valid = !faulted && (mq.size() > 0) && (mq[0].c + 2 <= cyc);
            exp_req   = (cyc >= 1) && !faulted && !redirect_valid &&
                        (mq.size() - int'(pop) < 2);
            check("instr_valid", {31'd0, instr_valid}, {31'd0, exp_valid});
            check("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
            if (mem_req) check("mem_addr", mem_addr, exp_req_pc);
            check("fetch_fault", {31'd0, fetch_fault}, {31'd0, faulted});
            if (pop && mq.size() > 0) begin
                check("instr_pc", instr_pc, mq[0].pc);
                check("instr", instr, mq[0].pc ^ KEY);
            end
            if (hold_v) begin
                check("hold_instr", instr, hold_i);
                check("hold_instr_pc", instr_pc, hold_p);
            end
            hold_v = instr_valid && !instr_ready && !redirect_valid;
            hold_i = instr;
            hold_p = instr_pc;

            if (redirect_valid && cyc >= 1) begin
                mq.delete();
                if (redirect_pc[1:0] != 2'b00) begin
                    faulted = 1'b1;
                end else begin
                    faulted    = 1'b0;
                    exp_req_pc = redirect_pc;
                end
            end else begin
                if (pop && mq.size() > 0) void'(mq.pop_front());
                if (mem_req) begin
                    mq.push_back('{c: cyc, pc: exp_req_pc});
                    exp_req_pc = exp_req_pc + 32'd4;
                end
            end
            cyc++;
        end
        gcyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] pc, output int t);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        t              = gcyc;
        tick(1);
        redirect_valid = 1'b0;
    endtask

    task automatic lit(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (idx >= 0 && idx < gcyc) check(name, act, exp);
        else check({name, "_idx"}, idx, gcyc);
    endtask

    initial begin
        int          g_rel, s, t_r, t_f, t_f2, t_a, t_w, g_rel2;
        logic [31:0] pattern;

        rstb           = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        tick(3);

        rstb  = 1'b1;
        g_rel = gcyc;
        tick(10);

        s = gcyc;
        instr_ready = 1'b0;
        tick(5);
        instr_ready = 1'b1;
        tick(10);

        // One entry queued and one response in flight when the redirect lands.
        instr_ready = 1'b0;
        redirect(32'h0000_0100, t_r);
        instr_ready = 1'b1;
        tick(8);

        redirect(32'h0000_0102, t_f);
        tick(4);
        redirect(32'h0000_0103, t_f2);
        tick(4);
        redirect(32'h0000_0200, t_a);
        tick(6);

        redirect(32'hFFFF_FFFC, t_w);
        tick(6);

        pattern = 32'hB3C5_1E6D;
        for (int i = 0; i < 32; i++) begin
            instr_ready = pattern[i];
            tick(1);
        end
        instr_ready = 1'b1;
        tick(4);

        rstb = 1'b0;
        tick(2);
        rstb   = 1'b1;
        g_rel2 = gcyc;
        tick(10);

        lit("boot_no_req", g_rel, {31'd0, tr_req[g_rel]}, 32'd0);
        lit("first_req", g_rel + 1, {31'd0, tr_req[g_rel + 1]}, 32'd1);
        lit("first_addr", g_rel + 1, tr_addr[g_rel + 1], 32'h0000_0000);
        lit("second_addr", g_rel + 2, tr_addr[g_rel + 2], 32'h0000_0004);
        lit("valid_c2", g_rel + 2, {31'd0, tr_valid[g_rel + 2]}, 32'd0);
        lit("valid_c3", g_rel + 3, {31'd0, tr_valid[g_rel + 3]}, 32'd1);
        lit("pc_c3", g_rel + 3, tr_pc[g_rel + 3], 32'h0000_0000);
        lit("pc_c4", g_rel + 4, tr_pc[g_rel + 4], 32'h0000_0004);

        lit("stall_no_req", s + 2, {31'd0, tr_req[s + 2]}, 32'd0);
        lit("stall_valid", s + 4, {31'd0, tr_valid[s + 4]}, 32'd1);
        lit("stall_resume_req", s + 5, {31'd0, tr_req[s + 5]}, 32'd1);

        lit("redir_no_req", t_r, {31'd0, tr_req[t_r]}, 32'd0);
        lit("redir_flushed", t_r + 1, {31'd0, tr_valid[t_r + 1]}, 32'd0);
        lit("redir_addr", t_r + 1, tr_addr[t_r + 1], 32'h0000_0100);
        lit("redir_stale_drop", t_r + 2, {31'd0, tr_valid[t_r + 2]}, 32'd0);
        lit("redir_pc", t_r + 3, tr_pc[t_r + 3], 32'h0000_0100);

        lit("fault_set", t_f + 1, {31'd0, tr_fault[t_f + 1]}, 32'd1);
        lit("fault_no_req", t_f + 3, {31'd0, tr_req[t_f + 3]}, 32'd0);
        lit("fault_no_valid", t_f + 3, {31'd0, tr_valid[t_f + 3]}, 32'd0);
        lit("fault_sticky", t_f2 + 2, {31'd0, tr_fault[t_f2 + 2]}, 32'd1);
        lit("fault_clear", t_a + 1, {31'd0, tr_fault[t_a + 1]}, 32'd0);
        lit("resume_addr", t_a + 1, tr_addr[t_a + 1], 32'h0000_0200);
        lit("resume_pc", t_a + 3, tr_pc[t_a + 3], 32'h0000_0200);

        lit("wrap_addr_top", t_w + 1, tr_addr[t_w + 1], 32'hFFFF_FFFC);
        lit("wrap_addr_zero", t_w + 2, tr_addr[t_w + 2], 32'h0000_0000);
        lit("wrap_pc_zero", t_w + 4, tr_pc[t_w + 4], 32'h0000_0000);

        lit("rerun_boot", g_rel2, {31'd0, tr_req[g_rel2]}, 32'd0);
        lit("rerun_addr", g_rel2 + 1, tr_addr[g_rel2 + 1], RST_PC);
        lit("rerun_valid", g_rel2 + 3, {31'd0, tr_valid[g_rel2 + 3]}, 32'd1);
        lit("rerun_pc", g_rel2 + 3, tr_pc[g_rel2 + 3], RST_PC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
